// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the chunked signed add/subtract unit.
package addsub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the saturation helpers can describe.
    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W-1:0] smin(input int unsigned width);
        return MAX_W'(1) << (width - 1);
    endfunction

    function automatic logic [MAX_W-1:0] smax(input int unsigned width);
        return smin(width) - MAX_W'(1);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder; also exposes the carry into its top bit for overflow detection.
module addsub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum   = w_full[CHUNK-1:0];
    assign o_cout  = w_full[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
    assign o_c_msb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule

// File: rtl/signed_addsub_seq.sv
// Multi-cycle signed add/subtract: CHUNK bits per cycle, start/done handshake, optional saturation.
module signed_addsub_seq
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_op,
    input  logic             i_sat_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf,
    output logic             o_neg,
    output logic             o_zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SAT_MIN  = WIDTH'(smin(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MAX  = WIDTH'(smax(WIDTH));

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_sat;
    logic             r_a_sign;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a     (r_a[CHUNK-1:0]),
        .i_b     (r_b[CHUNK-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    // Chunks enter at the top and shift down, so after NCHUNK steps chunk 0 sits at bit 0.
    assign w_sum_next = (r_sum >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));
    assign w_ovf      = w_c_msb ^ w_cout;
    assign w_result   = (r_sat && w_ovf) ? (r_a_sign ? SAT_MIN : SAT_MAX) : w_sum_next;

    // Final result is registered on the last RUN edge so it is valid throughout the FIN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_sat    <= 1'b0;
            r_a_sign <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a      <= i_a;
                        r_b      <= (i_op == OP_SUB) ? ~i_b : i_b;
                        r_carry  <= i_op;
                        r_sat    <= i_sat_en;
                        r_a_sign <= i_a[WIDTH-1];
                        r_cnt    <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_result <= w_result;
                        r_ovf    <= w_ovf;
                        r_state  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy   = (r_state == ST_RUN);
    assign o_done   = (r_state == ST_FIN);
    assign o_result = r_result;
    assign o_ovf    = r_ovf;
    assign o_neg    = r_result[WIDTH-1];
    assign o_zero   = (r_result == '0);

endmodule

// File: tb/tb_signed_addsub_seq.sv
// Scoreboard bench: 32/8 and 16/4 instances driven with hand-computed directed vectors.
module tb_signed_addsub_seq;

    localparam int N32 = 4;
    localparam int N16 = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        s32_start, s32_op, s32_sat;
    logic [31:0] s32_a, s32_b;
    logic        busy32, done32, ovf32, neg32, zero32;
    logic [31:0] res32;

    logic        s16_start, s16_op, s16_sat;
    logic [15:0] s16_a, s16_b;
    logic        busy16, done16, ovf16, neg16, zero16;
    logic [15:0] res16;

    signed_addsub_seq #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_start(s32_start), .i_op(s32_op), .i_sat_en(s32_sat),
        .i_a(s32_a), .i_b(s32_b), .o_busy(busy32), .o_done(done32), .o_result(res32),
        .o_ovf(ovf32), .o_neg(neg32), .o_zero(zero32)
    );

    signed_addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(s16_start), .i_op(s16_op), .i_sat_en(s16_sat),
        .i_a(s16_a), .i_b(s16_b), .o_busy(busy16), .o_done(done16), .o_result(res16),
        .o_ovf(ovf16), .o_neg(neg16), .o_zero(zero16)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   dones32 = 0;
    int   dones16 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (done32 === 1'b1) begin
            dones32++;
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d32 unexpected done: got result 0x%08h, expected no done", res32);
            end else begin
                e = q32.pop_front();
                chk("d32 result", res32, e.res);
                chk("d32 ovf", {31'b0, ovf32}, {31'b0, e.ovf});
                chk("d32 neg", {31'b0, neg32}, {31'b0, e.res[31]});
                chk("d32 zero", {31'b0, zero32}, {31'b0, (e.res == 32'h0)});
                chk("d32 latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (done16 === 1'b1) begin
            dones16++;
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d16 unexpected done: got result 0x%04h, expected no done", res16);
            end else begin
                e = q16.pop_front();
                chk("d16 result", {16'b0, res16}, {16'b0, e.res[15:0]});
                chk("d16 ovf", {31'b0, ovf16}, {31'b0, e.ovf});
                chk("d16 neg", {31'b0, neg16}, {31'b0, e.res[15]});
                chk("d16 zero", {31'b0, zero16}, {31'b0, (e.res[15:0] == 16'h0)});
                chk("d16 latency", cyc, e.cyc);
            end
        end
    end

    // Wait for the scoreboard queue to drain, bounded; an expired bound counts as a failure.
    task automatic drain(input bit sel16);
        int n;
        for (int i = 0; i < 12; i++) begin
            n = sel16 ? q16.size() : q32.size();
            if (n == 0) break;
            @(negedge clk);
        end
        n = sel16 ? q16.size() : q32.size();
        if (n != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d pending, expected 0", sel16 ? "d16" : "d32", n);
            if (sel16) q16.delete(); else q32.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue32(input logic op, input logic sat, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic ovf);
        exp_t e;
        @(negedge clk);
        s32_start = 1'b1; s32_op = op; s32_sat = sat; s32_a = a; s32_b = b;
        e.res = res; e.ovf = ovf; e.cyc = cyc + 1 + N32;
        q32.push_back(e);
        @(negedge clk);
        s32_start = 1'b0; s32_op = ~op; s32_sat = ~sat; s32_a = ~a; s32_b = ~b;
        drain(1'b0);
    endtask

    task automatic issue16(input logic op, input logic sat, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] res, input logic ovf);
        exp_t e;
        @(negedge clk);
        s16_start = 1'b1; s16_op = op; s16_sat = sat; s16_a = a; s16_b = b;
        e.res = {16'b0, res}; e.ovf = ovf; e.cyc = cyc + 1 + N16;
        q16.push_back(e);
        @(negedge clk);
        s16_start = 1'b0; s16_op = ~op; s16_sat = ~sat; s16_a = ~a; s16_b = ~b;
        drain(1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        int   d0;
        s32_start = 0; s32_op = 0; s32_sat = 0; s32_a = '0; s32_b = '0;
        s16_start = 0; s16_op = 0; s16_sat = 0; s16_a = '0; s16_b = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'b0, busy32}, 32'h0);
        chk("reset done", {31'b0, done32}, 32'h0);
        chk("reset result", res32, 32'h0);
        chk("reset ovf", {31'b0, ovf32}, 32'h0);
        chk("reset zero", {31'b0, zero32}, 32'h1);
        chk("reset16 zero", {31'b0, zero16}, 32'h1);

        d0 = dones32;
        repeat (10) @(negedge clk);
        chk("idle no done", dones32, d0);

        issue32(1'b0, 1'b0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002, 1'b0);
        issue32(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
        issue32(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1);
        issue32(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
        issue32(1'b1, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0);
        issue32(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
        issue32(1'b1, 1'b0, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1);
        issue32(1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        issue32(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
        issue32(1'b0, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'h2143_6587, 1'b0);
        issue32(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0);
        issue32(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        issue32(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // start pulsed mid-RUN with other operands must be ignored
        @(negedge clk);
        s32_start = 1'b1; s32_op = 1'b0; s32_sat = 1'b0; s32_a = 32'h10; s32_b = 32'h20;
        e.res = 32'h30; e.ovf = 1'b0; e.cyc = cyc + 1 + N32;
        q32.push_back(e);
        @(negedge clk);
        s32_start = 1'b0;
        chk("busy in run", {31'b0, busy32}, 32'h1);
        @(negedge clk);
        s32_start = 1'b1; s32_op = 1'b1; s32_a = 32'h1111_1111; s32_b = 32'h2222_2222;
        @(negedge clk);
        s32_start = 1'b0;
        drain(1'b0);
        repeat (6) @(negedge clk);

        // start held high: FIN-cycle start ignored, next accept the cycle after done
        @(negedge clk);
        s32_start = 1'b1; s32_op = 1'b0; s32_sat = 1'b0; s32_a = 32'h3; s32_b = 32'h4;
        e.res = 32'h7; e.ovf = 1'b0; e.cyc = cyc + 1 + N32;
        q32.push_back(e);
        e.cyc = cyc + 2 * N32 + 3;
        q32.push_back(e);
        repeat (N32 + 3) @(negedge clk);
        s32_start = 1'b0;
        drain(1'b0);

        issue16(1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0);
        issue16(1'b0, 1'b0, 16'h7000, 16'h1000, 16'h8000, 1'b1);
        issue16(1'b0, 1'b1, 16'h7000, 16'h1000, 16'h7FFF, 1'b1);
        issue16(1'b1, 1'b1, 16'h0000, 16'h8000, 16'h7FFF, 1'b1);
        issue16(1'b1, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b0);
        issue16(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
        issue16(1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
        issue16(1'b1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1);
        issue16(1'b0, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0);

        // reset in cycle T+2 aborts the op with no done pulse
        d0 = dones32;
        @(negedge clk);
        s32_start = 1'b1; s32_op = 1'b0; s32_sat = 1'b0; s32_a = 32'h1; s32_b = 32'h1;
        @(negedge clk);
        s32_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", {31'b0, busy32}, 32'h0);
        chk("abort done", {31'b0, done32}, 32'h0);
        chk("abort result", res32, 32'h0);
        chk("abort ovf", {31'b0, ovf32}, 32'h0);
        chk("abort neg", {31'b0, neg32}, 32'h0);
        chk("abort zero", {31'b0, zero32}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort no done", dones32, d0);

        issue32(1'b0, 1'b0, 32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
